// File: rtl/nsalu_pkg.sv
// Shared definitions for the nibble-serial ALU.
//   state_e  : sequencer states
//   OP_ADD / OP_SUB : encodings of the op input
//   NIBBLE_W : width of one slice handled by the shared adder per clock
package nsalu_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   localparam logic OP_ADD = 1'b0;
   localparam logic OP_SUB = 1'b1;

   localparam int unsigned NIBBLE_W = 4;

endpackage

// File: rtl/adder.sv
// 4-bit ripple adder shared across the tile.
// Ports:
//   A, B : addends
//   CI   : carry in
//   Y    : sum
//   C    : carry out of bit 3
//   V    : signed overflow (carry into bit 3 XOR carry out of bit 3)
module adder (
   input  logic [3:0] A,
   input  logic [3:0] B,
   input  logic       CI,
   output logic [3:0] Y,
   output logic       C,
   output logic       V
);

   logic [4:0] sum;
   logic       carry_into_msb;

   assign sum = {1'b0, A} + {1'b0, B} + {4'b0000, CI};
   assign Y   = sum[3:0];
   assign C   = sum[4];

   // Sum bit 3 = A3 ^ B3 ^ c3, so c3 falls out of the sum directly.
   assign carry_into_msb = A[3] ^ B[3] ^ sum[3];
   assign V              = carry_into_msb ^ C;

endmodule

// File: rtl/nibble_serial_alu.sv
// Wide add/subtract built by walking the operands one nibble per clock through
// a single shared 4-bit adder, LSB nibble first, with the carry held between
// nibbles. Subtraction is A + ~B + ~borrow_in.
// Ports:
//   clk, rst_n          : clock, synchronous active-low reset
//   start               : request, only honoured when idle
//   op                  : 0 = ADD, 1 = SUB
//   ci_in               : carry-in (ADD) or borrow-in (SUB)
//   a_in, b_in          : operands, latched on an accepted start
//   busy                : high while running and during the done cycle
//   done                : one-cycle completion pulse
//   result              : final value, held until the next completion
//   flag_c/v/z/n        : carry (SUB: 1 = no borrow), overflow, zero, negative
module nibble_serial_alu
   import nsalu_pkg::*;
#(
   parameter int unsigned NIBBLES = 4
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      start,
   input  logic                      op,
   input  logic                      ci_in,
   input  logic [NIBBLE_W*NIBBLES-1:0] a_in,
   input  logic [NIBBLE_W*NIBBLES-1:0] b_in,
   output logic                      busy,
   output logic                      done,
   output logic [NIBBLE_W*NIBBLES-1:0] result,
   output logic                      flag_c,
   output logic                      flag_v,
   output logic                      flag_z,
   output logic                      flag_n
);

   localparam int unsigned W  = NIBBLE_W * NIBBLES;
   localparam int unsigned KW = $clog2(NIBBLES);
   localparam logic [KW-1:0] K_LAST = KW'(NIBBLES - 1);

   state_e           state_q, state_d;
   logic [KW-1:0]    k_q, k_d;
   logic [W-1:0]     a_q, a_d;
   logic [W-1:0]     b_q, b_d;
   logic [W-1:0]     acc_q, acc_d;
   logic [W-1:0]     result_q, result_d;
   logic             op_q, op_d;
   logic             carry_q, carry_d;
   logic             c_q, c_d, v_q, v_d, z_q, z_d, n_q, n_d;

   logic [NIBBLE_W-1:0] add_a, add_b, add_y;
   logic                add_c, add_v;

   // Nibble k starts at bit 4k; appending two zeros is the multiply by four.
   assign add_a = a_q[{k_q, 2'b00} +: NIBBLE_W];
   assign add_b = (op_q == OP_SUB) ? ~b_q[{k_q, 2'b00} +: NIBBLE_W]
                                   :  b_q[{k_q, 2'b00} +: NIBBLE_W];

   adder u_adder (
      .A  (add_a),
      .B  (add_b),
      .CI (carry_q),
      .Y  (add_y),
      .C  (add_c),
      .V  (add_v)
   );

   always_comb begin
      state_d  = state_q;
      k_d      = k_q;
      a_d      = a_q;
      b_d      = b_q;
      acc_d    = acc_q;
      result_d = result_q;
      op_d     = op_q;
      carry_d  = carry_q;
      c_d      = c_q;
      v_d      = v_q;
      z_d      = z_q;
      n_d      = n_q;

      case (state_q)
         IDLE: begin
            if (start) begin
               a_d     = a_in;
               b_d     = b_in;
               op_d    = op;
               // Borrow-in becomes the inverted carry-in of A + ~B.
               carry_d = (op == OP_ADD) ? ci_in : ~ci_in;
               k_d     = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            acc_d[{k_q, 2'b00} +: NIBBLE_W] = add_y;
            carry_d = add_c;
            k_d     = k_q + 1'b1;
            if (k_q == K_LAST) begin
               // acc_d already holds the top nibble, so flags see the full value.
               result_d = acc_d;
               c_d      = add_c;
               v_d      = add_v;
               z_d      = (acc_d == '0);
               n_d      = acc_d[W-1];
               state_d  = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         k_q      <= '0;
         a_q      <= '0;
         b_q      <= '0;
         acc_q    <= '0;
         result_q <= '0;
         op_q     <= 1'b0;
         carry_q  <= 1'b0;
         c_q      <= 1'b0;
         v_q      <= 1'b0;
         z_q      <= 1'b0;
         n_q      <= 1'b0;
      end else begin
         state_q  <= state_d;
         k_q      <= k_d;
         a_q      <= a_d;
         b_q      <= b_d;
         acc_q    <= acc_d;
         result_q <= result_d;
         op_q     <= op_d;
         carry_q  <= carry_d;
         c_q      <= c_d;
         v_q      <= v_d;
         z_q      <= z_d;
         n_q      <= n_d;
      end
   end

   assign busy   = (state_q != IDLE);
   assign done   = (state_q == DONE);
   assign result = result_q;
   assign flag_c = c_q;
   assign flag_v = v_q;
   assign flag_z = z_q;
   assign flag_n = n_q;

endmodule

// File: tb/tb_nibble_serial_alu.sv
// Self-checking bench for nibble_serial_alu (NIBBLES = 4): directed vector
// table, randomized operations against an arithmetic reference model, and
// hand-written sequences for start-while-busy and mid-run reset.
module tb_nibble_serial_alu;

   localparam int unsigned NIBBLES = 4;
   localparam int unsigned W       = 4 * NIBBLES;
   localparam int          LAT     = NIBBLES;   // edges after the start edge

   logic         clk;
   logic         rst_n;
   logic         start;
   logic         op;
   logic         ci_in;
   logic [W-1:0] a_in;
   logic [W-1:0] b_in;
   logic         busy;
   logic         done;
   logic [W-1:0] result;
   logic         flag_c, flag_v, flag_z, flag_n;

   int n_cmp = 0;
   int n_bad = 0;

   nibble_serial_alu #(
      .NIBBLES (NIBBLES)
   ) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .start  (start),
      .op     (op),
      .ci_in  (ci_in),
      .a_in   (a_in),
      .b_in   (b_in),
      .busy   (busy),
      .done   (done),
      .result (result),
      .flag_c (flag_c),
      .flag_v (flag_v),
      .flag_z (flag_z),
      .flag_n (flag_n)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   typedef struct {
      logic         op;
      logic         ci;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] res;
      logic [3:0]   flg;   // {C, V, Z, N}
   } vec_t;

   vec_t vecs[7];

   task automatic chk(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   function automatic logic [3:0] flags_now();
      return {flag_c, flag_v, flag_z, flag_n};
   endfunction

   // Reference: plain integer arithmetic on the whole operands.
   // Returns {C, V, Z, N, result}.
   function automatic logic [W+3:0] model(input logic o, input logic c,
                                          input logic [W-1:0] a, input logic [W-1:0] b);
      longint       m, ua, ub, sa, sb, full, s;
      logic [W-1:0] r;
      logic         cf, vf;
      m  = longint'(1) << W;
      ua = longint'(a);
      ub = longint'(b);
      sa = a[W-1] ? ua - m : ua;
      sb = b[W-1] ? ub - m : ub;
      if (o == 1'b0) begin
         full = ua + ub + longint'(c);
         s    = sa + sb + longint'(c);
      end else begin
         // +m so that "no borrow" shows up as carry out = 1
         full = ua - ub - longint'(c) + m;
         s    = sa - sb - longint'(c);
      end
      r  = full[W-1:0];
      cf = full[W];
      vf = (s > (m / 2) - 1) || (s < -(m / 2));
      return {cf, vf, (r == '0), r[W-1], r};
   endfunction

   // Issues one operation and returns the number of edges after the start
   // edge until done is seen (bounded). Leaves time #1 after that edge.
   task automatic do_op(input logic o, input logic c, input logic [W-1:0] a,
                        input logic [W-1:0] b, output int lat);
      @(negedge clk);
      op    = o;
      ci_in = c;
      a_in  = a;
      b_in  = b;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      // Scramble inputs to show the operands were latched.
      op    = 1'($urandom);
      ci_in = 1'($urandom);
      a_in  = W'($urandom);
      b_in  = W'($urandom);
      lat   = 0;
      while (done !== 1'b1 && lat < 20) begin
         @(posedge clk);
         #1;
         lat++;
      end
   endtask

   task automatic chk_pulse_end(input string name);
      @(posedge clk);
      #1;
      chk(name, W'({busy, done}), W'(2'b00));
   endtask

   function automatic logic [W-1:0] pick_operand();
      logic [W-1:0] v;
      logic [W-1:0] corners[4];
      corners[0] = '0;
      corners[1] = '1;
      corners[2] = {1'b1, {(W-1){1'b0}}};
      corners[3] = {1'b0, {(W-1){1'b1}}};
      if ($urandom_range(3) == 0) v = corners[$urandom_range(3)];
      else                        v = W'($urandom);
      return v;
   endfunction

   initial begin
      int           lat;
      int           cnt;
      int           dn_cnt;
      logic         ro, rc;
      logic [W-1:0] ra, rb;
      logic [W+3:0] exp;

      vecs[0] = '{1'b0, 1'b0, 16'h1234, 16'h4321, 16'h5555, 4'b0000};
      vecs[1] = '{1'b0, 1'b0, 16'hFFFF, 16'h0001, 16'h0000, 4'b1010};
      vecs[2] = '{1'b0, 1'b0, 16'h7FFF, 16'h0001, 16'h8000, 4'b0101};
      vecs[3] = '{1'b1, 1'b0, 16'h0005, 16'h0007, 16'hFFFE, 4'b0001};
      vecs[4] = '{1'b1, 1'b0, 16'h8000, 16'h0001, 16'h7FFF, 4'b1100};
      vecs[5] = '{1'b1, 1'b1, 16'h0010, 16'h0001, 16'h000E, 4'b1000};
      vecs[6] = '{1'b0, 1'b1, 16'h0FFF, 16'h0000, 16'h1000, 4'b0000};

      rst_n = 1'b0;
      start = 1'b0;
      op    = 1'b0;
      ci_in = 1'b0;
      a_in  = '0;
      b_in  = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      chk("reset_busy_done", W'({busy, done}), W'(2'b00));
      chk("reset_result", result, '0);
      chk("reset_flags", W'(flags_now()), W'(4'b0000));

      // Directed table
      for (int i = 0; i < 7; i++) begin
         do_op(vecs[i].op, vecs[i].ci, vecs[i].a, vecs[i].b, lat);
         chk($sformatf("vec%0d_latency", i), W'(lat), W'(LAT));
         chk($sformatf("vec%0d_result", i), result, vecs[i].res);
         chk($sformatf("vec%0d_flags", i), W'(flags_now()), W'(vecs[i].flg));
         chk_pulse_end($sformatf("vec%0d_done_pulse", i));
      end

      // Randomized against the model
      for (int i = 0; i < 40; i++) begin
         ro  = 1'($urandom);
         rc  = 1'($urandom);
         ra  = pick_operand();
         rb  = pick_operand();
         exp = model(ro, rc, ra, rb);
         repeat ($urandom_range(2)) @(posedge clk);
         do_op(ro, rc, ra, rb, lat);
         chk($sformatf("rnd%0d_latency", i), W'(lat), W'(LAT));
         chk($sformatf("rnd%0d_result", i), result, exp[W-1:0]);
         chk($sformatf("rnd%0d_flags", i), W'(flags_now()), W'(exp[W+3:W]));
         chk_pulse_end($sformatf("rnd%0d_done_pulse", i));
      end

      // Start while busy: mid-run and in the done cycle are ignored,
      // the following idle cycle accepts.
      @(negedge clk);
      op = 1'b0; ci_in = 1'b0; a_in = 16'h1111; b_in = 16'h2222; start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      @(posedge clk);
      #1;
      op = 1'b1; a_in = 16'hFFFF; b_in = 16'h0001; start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      cnt = 2;
      while (done !== 1'b1 && cnt < 20) begin
         @(posedge clk);
         #1;
         cnt++;
      end
      chk("b2b_latency", W'(cnt), W'(LAT));
      chk("b2b_result", result, 16'h3333);
      op = 1'b0; ci_in = 1'b0; a_in = 16'h8000; b_in = 16'h0001; start = 1'b1;
      @(posedge clk);
      #1;
      chk("b2b_done_start_ignored", W'({busy, done}), W'(2'b00));
      chk("b2b_result_held", result, 16'h3333);
      @(posedge clk);
      #1;
      start = 1'b0;
      chk("b2b_idle_accept", W'(busy), W'(1'b1));
      @(posedge clk);
      #1;
      chk("b2b_no_partial", result, 16'h3333);
      cnt = 1;
      while (done !== 1'b1 && cnt < 20) begin
         @(posedge clk);
         #1;
         cnt++;
      end
      chk("b2b2_latency", W'(cnt), W'(LAT));
      chk("b2b2_result", result, 16'h8001);
      chk("b2b2_flags", W'(flags_now()), W'(4'b0001));
      chk_pulse_end("b2b2_done_pulse");

      // Reset in the second RUN cycle discards the operation.
      @(negedge clk);
      op = 1'b0; ci_in = 1'b0; a_in = 16'hFFFF; b_in = 16'hFFFF; start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      chk("rst_busy_done", W'({busy, done}), W'(2'b00));
      chk("rst_result", result, '0);
      chk("rst_flags", W'(flags_now()), W'(4'b0000));
      dn_cnt = 0;
      repeat (8) begin
         @(posedge clk);
         #1;
         if (done === 1'b1) dn_cnt++;
      end
      chk("rst_no_done", W'(dn_cnt), W'(0));
      do_op(1'b0, 1'b0, 16'h1234, 16'h4321, lat);
      chk("post_rst_latency", W'(lat), W'(LAT));
      chk("post_rst_result", result, 16'h5555);
      chk("post_rst_flags", W'(flags_now()), W'(4'b0000));
      chk_pulse_end("post_rst_done_pulse");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
